fifo_read_checker: RTL and testbench
====================================

// Module: fifo_read_checker
// PURPOSE
//  Read-side consumer for the asynchronous FIFO, clocked in the read domain.
//  - Pops words whenever the FIFO is non-empty (optional throttle gap between pops).
//  - Checks each popped word against the arithmetic ramp the write-side source produces (k*STEP).
//  - Reports word count, error count and first-failure capture to the bench or status logic.
// PARAMETERS
//  W        8    data width; must match the FIFO data width
//  CNT_W    16   width of word_count, err_count and first_err_idx
//  WORDS    128  words to consume before DONE; must be 1..2^CNT_W-1
//  EXP_INIT 0    expected value of the first word
//  EXP_STEP 2    increment applied to the expected value after every pop (mod 2^W)
//  GAP      0    idle cycles forced after each pop, 0..255; 0 allows a pop every cycle
// PORTS
//  read_clk       in   1      single clock, FIFO read domain
//  reset          in   1      synchronous, active-high
//  start          in   1      in IDLE or DONE: begin a new run; ignored in RUN
//  r_empty        in   1      FIFO empty flag
//  data_in        in   W      FIFO data_out; first-word-fall-through, valid while r_empty=0
//  rd_en          out  1      pop request; the FIFO advances on a read_clk edge where rd_en=1
//  busy           out  1      1 while in RUN
//  done           out  1      1 while in DONE
//  err_flag       out  1      1 once any mismatch has been seen in the current run
//  word_count     out  CNT_W  words popped in the current run
//  err_count      out  CNT_W  mismatches in the current run; saturates at all-ones
//  first_err_idx  out  CNT_W  index (0-based) of the first mismatching word
//  first_err_data out  W      data value of the first mismatching word
// BEHAVIOUR
//  Reset: sampled on read_clk posedge.
//   - State goes to IDLE; all registered outputs go to 0; expected is loaded with EXP_INIT; gap_cnt goes to 0.
//   - rd_en is forced to 0 combinationally whenever reset=1.
//   - Reset mid-run abandons the run; no partial status is retained.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE, start=1: go to RUN next edge.
//   - RUN, pop on word index WORDS-1: go to DONE next edge.
//   - DONE, start=1: go to RUN next edge.
//   - Every entry to RUN clears word_count, err_count, err_flag, first_err_*, gap_cnt and reloads expected=EXP_INIT.
//  rd_en = !reset & (state==RUN) & !r_empty & (gap_cnt==0). It is combinational; there are no registered pops.
//  Pop = read_clk edge where rd_en=1. At that edge data_in is sampled, with zero latency, as the word for index=word_count.
//   - mismatch = (data_in != expected).
//   - expected <= expected + EXP_STEP, truncated to W bits.
//   - word_count <= word_count + 1.
//   - If mismatch: err_count increments (holds at all-ones) and err_flag <= 1.
//   - If mismatch and err_flag was 0: first_err_idx <= word_count, first_err_data <= data_in.
//   - gap_cnt <= GAP.
//  Non-pop cycle: if gap_cnt != 0 it decrements; all other state holds.
//   - This covers r_empty=1 and gap cycles. A gap elapses even while the FIFO is empty.
//  busy = (state==RUN); done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
//  Simultaneous events:
//   - The last pop and the transition to DONE happen on the same edge; no further rd_en follows.
//   - start in RUN is ignored.
//   - start held high in DONE restarts a new run.
//  In IDLE and DONE, rd_en=0 regardless of r_empty. Status outputs hold their values in DONE until the next start.
// TESTING
//  1 reset; start; FIFO holds 0,2,..,254 (128 words), GAP=0
//    -> 128 back-to-back rd_en cycles
//    -> done=1, word_count=128, err_count=0, err_flag=0
//  2 As test 1, but word 5 is 0x0B instead of 0x0A
//    -> err_count=1, err_flag=1, first_err_idx=5, first_err_data=0x0B
//    -> the remaining words check clean
//  3 r_empty forced to 1 for 10 cycles after word 30
//    -> rd_en=0 for those 10 cycles and word_count holds at 31
//    -> checking resumes at expected=62, with no false errors
//  4 GAP=3, FIFO always non-empty
//    -> rd_en high 1 cycle, then low exactly 3 cycles, repeating
//    -> done after 128 pops
//  5 reset pulsed for 1 cycle at word 40
//    -> rd_en=0 during the reset cycle; outputs are 0 and state is IDLE next edge
//    -> after a new start, word 0 is expected to be 0x00
//  6 WORDS=200, EXP_STEP=2
//    -> word 128 is expected to be 0x00 (wrap) and matches
//    -> final word_count=200, err_count=0

Source files
------------

// File: rtl/fifo_read_checker.sv
// Read-domain consumer for the asynchronous FIFO: pops words while data is available and
// checks each one against the EXP_INIT + k*EXP_STEP ramp produced by the write-side source.
module fifo_read_checker #(
    parameter int W        = 8,
    parameter int CNT_W    = 16,
    parameter int WORDS    = 128,
    parameter int EXP_INIT = 0,
    parameter int EXP_STEP = 2,
    parameter int GAP      = 0
) (
    input  logic             read_clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             r_empty_i,
    input  logic [W-1:0]     data_in_i,
    output logic             rd_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_flag_o,
    output logic [CNT_W-1:0] word_count_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] first_err_idx_o,
    output logic [W-1:0]     first_err_data_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [W-1:0]     INIT_V   = W'(EXP_INIT);
    localparam logic [W-1:0]     STEP_V   = W'(EXP_STEP);
    localparam logic [7:0]       GAP_V    = 8'(GAP);

    state_t           state_q, state_d;
    logic [W-1:0]     expected_q, expected_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_flag_q, err_flag_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic [W-1:0]     first_err_data_q, first_err_data_d;

    logic pop;
    logic mismatch;

    // The pop is purely combinational: the FIFO is first-word-fall-through, so the word
    // on data_in_i is consumed on the same edge that rd_en_o is seen high.
    always_comb begin
        pop      = !reset_i && (state_q == RUN) && !r_empty_i && (gap_cnt_q == 8'd0);
        mismatch = (data_in_i != expected_q);
    end

    always_comb begin
        state_d          = state_q;
        expected_d       = expected_q;
        gap_cnt_d        = gap_cnt_q;
        word_count_d     = word_count_q;
        err_count_d      = err_count_q;
        err_flag_d       = err_flag_q;
        first_err_idx_d  = first_err_idx_q;
        first_err_data_d = first_err_data_q;

        if (pop) begin
            expected_d   = expected_q + STEP_V;
            word_count_d = word_count_q + 1'b1;
            gap_cnt_d    = GAP_V;
            if (mismatch) begin
                err_flag_d = 1'b1;
                if (err_count_q != CNT_MAX) begin
                    err_count_d = err_count_q + 1'b1;
                end
                if (!err_flag_q) begin
                    first_err_idx_d  = word_count_q;
                    first_err_data_d = data_in_i;
                end
            end
        end else if (gap_cnt_q != 8'd0) begin
            gap_cnt_d = gap_cnt_q - 8'd1;
        end

        // Entering RUN starts a fresh run; this overrides the hold/decrement above.
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d          = RUN;
                    expected_d       = INIT_V;
                    gap_cnt_d        = 8'd0;
                    word_count_d     = '0;
                    err_count_d      = '0;
                    err_flag_d       = 1'b0;
                    first_err_idx_d  = '0;
                    first_err_data_d = '0;
                end
            end
            RUN: begin
                if (pop && (word_count_q == LAST_IDX)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge read_clk_i) begin
        if (reset_i) begin
            state_q          <= IDLE;
            expected_q       <= INIT_V;
            gap_cnt_q        <= 8'd0;
            word_count_q     <= '0;
            err_count_q      <= '0;
            err_flag_q       <= 1'b0;
            first_err_idx_q  <= '0;
            first_err_data_q <= '0;
        end else begin
            state_q          <= state_d;
            expected_q       <= expected_d;
            gap_cnt_q        <= gap_cnt_d;
            word_count_q     <= word_count_d;
            err_count_q      <= err_count_d;
            err_flag_q       <= err_flag_d;
            first_err_idx_q  <= first_err_idx_d;
            first_err_data_q <= first_err_data_d;
        end
    end

    assign rd_en_o          = pop;
    assign busy_o           = (state_q == RUN);
    assign done_o           = (state_q == DONE);
    assign err_flag_o       = err_flag_q;
    assign word_count_o     = word_count_q;
    assign err_count_o      = err_count_q;
    assign first_err_idx_o  = first_err_idx_q;
    assign first_err_data_o = first_err_data_q;

endmodule

// File: tb/tb_fifo_read_checker.sv
// Bench for fifo_read_checker: two instances (128 words/no gap, 200 words/gap 3) fed from a
// queue-based FIFO model and checked against a ramp model computed from the word index.
module tb_fifo_read_checker;

    localparam int EXP_INIT = 0;
    localparam int EXP_STEP = 2;
    localparam int WORDS_A  = 128;
    localparam int WORDS_B  = 200;
    localparam int GAP_A    = 0;
    localparam int GAP_B    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startSig  [2];
    logic        rEmpty    [2];
    logic [7:0]  dataIn    [2];
    logic        rdEn      [2];
    logic        busy      [2];
    logic        done      [2];
    logic        errFlag   [2];
    logic [15:0] wordCount [2];
    logic [15:0] errCount  [2];
    logic [15:0] firstIdx  [2];
    logic [7:0]  firstData [2];

    int passCount  = 0;
    int totalCount = 0;

    logic [7:0] fifoQ[$];
    int         popCycles[$];
    int         activeSel   = 0;
    bit         startReq    = 1'b0;
    bit         forceEmpty  = 1'b0;
    int         emptyPct    = 0;
    int         cycleNo     = 0;

    bit mRun, mDone, mFlag;
    int mCount, mErr, mFirstIdx, mFirstData, mGap;

    always #5 clk = ~clk;

    fifo_read_checker #(
        .W(8), .CNT_W(16), .WORDS(WORDS_A), .EXP_INIT(EXP_INIT), .EXP_STEP(EXP_STEP), .GAP(GAP_A)
    ) dutA (
        .read_clk_i(clk), .reset_i(rst), .start_i(startSig[0]), .r_empty_i(rEmpty[0]),
        .data_in_i(dataIn[0]), .rd_en_o(rdEn[0]), .busy_o(busy[0]), .done_o(done[0]),
        .err_flag_o(errFlag[0]), .word_count_o(wordCount[0]), .err_count_o(errCount[0]),
        .first_err_idx_o(firstIdx[0]), .first_err_data_o(firstData[0])
    );

    fifo_read_checker #(
        .W(8), .CNT_W(16), .WORDS(WORDS_B), .EXP_INIT(EXP_INIT), .EXP_STEP(EXP_STEP), .GAP(GAP_B)
    ) dutB (
        .read_clk_i(clk), .reset_i(rst), .start_i(startSig[1]), .r_empty_i(rEmpty[1]),
        .data_in_i(dataIn[1]), .rd_en_o(rdEn[1]), .busy_o(busy[1]), .done_o(done[1]),
        .err_flag_o(errFlag[1]), .word_count_o(wordCount[1]), .err_count_o(errCount[1]),
        .first_err_idx_o(firstIdx[1]), .first_err_data_o(firstData[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic modelReset();
        mRun = 0; mDone = 0; mFlag = 0;
        mCount = 0; mErr = 0; mFirstIdx = 0; mFirstData = 0; mGap = 0;
    endtask

    function automatic int modelWords(input int sel);
        return (sel == 0) ? WORDS_A : WORDS_B;
    endfunction

    function automatic int modelGap(input int sel);
        return (sel == 0) ? GAP_A : GAP_B;
    endfunction

    // One read_clk cycle: drive the FIFO view, check rd_en, advance the model across the edge.
    task automatic applyStimulus();
        int   a;
        bit   emptyNow, expRd, popped;
        logic [7:0] expWord;
        a = activeSel;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            if (s != a) begin
                rEmpty[s]   = 1'b1;
                startSig[s] = 1'b0;
                dataIn[s]   = 8'h00;
            end
        end
        emptyNow = forceEmpty || (fifoQ.size() == 0) ||
                   (emptyPct > 0 && $urandom_range(99) < emptyPct);
        startSig[a] = startReq;
        rEmpty[a]   = emptyNow;
        dataIn[a]   = (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;
        #1;
        expRd = !rst && mRun && !emptyNow && (mGap == 0);
        checkOutput("rd_en", 32'(rdEn[a]), 32'(expRd));
        popped = rdEn[a];
        if (rst) begin
            modelReset();
        end else if (expRd) begin
            expWord = 8'((EXP_INIT + mCount * EXP_STEP) % 256);
            if (dataIn[a] != expWord) begin
                if (mErr < 65535) mErr++;
                if (!mFlag) begin
                    mFirstIdx  = mCount;
                    mFirstData = int'(dataIn[a]);
                end
                mFlag = 1;
            end
            mCount++;
            mGap = modelGap(a);
            popCycles.push_back(cycleNo);
            if (mCount == modelWords(a)) begin
                mRun  = 0;
                mDone = 1;
            end
        end else begin
            if (mGap != 0) mGap--;
            if (!mRun && startReq) begin
                mRun = 1; mDone = 0; mFlag = 0;
                mCount = 0; mErr = 0; mFirstIdx = 0; mFirstData = 0; mGap = 0;
            end
        end
        @(posedge clk);
        if (popped && fifoQ.size() != 0) void'(fifoQ.pop_front());
        cycleNo++;
        #1;
    endtask

    task automatic checkStatus(input string tag, input int sel);
        checkOutput({tag, "_busy"},      32'(busy[sel]),      32'(mRun));
        checkOutput({tag, "_done"},      32'(done[sel]),      32'(mDone));
        checkOutput({tag, "_err_flag"},  32'(errFlag[sel]),   32'(mFlag));
        checkOutput({tag, "_words"},     32'(wordCount[sel]), 32'(mCount));
        checkOutput({tag, "_errs"},      32'(errCount[sel]),  32'(mErr));
        checkOutput({tag, "_first_idx"}, 32'(firstIdx[sel]),  32'(mFirstIdx));
        checkOutput({tag, "_first_dat"}, 32'(firstData[sel]), 32'(mFirstData));
    endtask

    task automatic loadRamp(input int n);
        fifoQ.delete();
        for (int i = 0; i < n; i++) fifoQ.push_back(8'((EXP_INIT + i * EXP_STEP) % 256));
    endtask

    task automatic startRun();
        startReq = 1'b1;
        applyStimulus();
        startReq = 1'b0;
    endtask

    task automatic runUntilDone(input string tag, input int budget);
        int n = 0;
        while (mRun && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_timeout"}, 32'(mRun), 32'd0);
    endtask

    task automatic runUntilCount(input string tag, input int target, input int budget);
        int n = 0;
        while (mCount < target && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_reach"}, 32'(mCount >= target), 32'd1);
    endtask

    initial begin
        int badGaps;
        for (int s = 0; s < 2; s++) begin
            startSig[s] = 1'b0;
            rEmpty[s]   = 1'b1;
            dataIn[s]   = 8'h00;
        end
        modelReset();

        // Reset state of both instances
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        checkStatus("reset_a", 0);
        checkStatus("reset_b", 1);

        // Clean ramp, back-to-back pops
        activeSel = 0;
        loadRamp(WORDS_A);
        popCycles.delete();
        startRun();
        runUntilDone("t1", 400);
        checkStatus("t1", 0);
        checkOutput("t1_pops", 32'(popCycles.size()), 32'd128);
        checkOutput("t1_span", 32'(popCycles[$] - popCycles[0]), 32'd127);

        // Word 5 corrupted; start held high for a few RUN cycles must be ignored
        loadRamp(WORDS_A);
        fifoQ[5] = 8'h0B;
        startReq = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();
        startReq = 1'b0;
        runUntilDone("t2", 400);
        checkStatus("t2", 0);
        checkOutput("t2_first_idx", 32'(firstIdx[0]), 32'd5);
        checkOutput("t2_first_dat", 32'(firstData[0]), 32'h0B);
        checkOutput("t2_errs", 32'(errCount[0]), 32'd1);

        // FIFO starved for 10 cycles after word 30
        loadRamp(WORDS_A);
        startRun();
        runUntilCount("t3", 31, 200);
        forceEmpty = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus();
        forceEmpty = 1'b0;
        checkOutput("t3_hold", 32'(wordCount[0]), 32'd31);
        runUntilDone("t3", 400);
        checkStatus("t3", 0);
        checkOutput("t3_errs", 32'(errCount[0]), 32'd0);

        // Random stalls and random corruption
        fifoQ.delete();
        for (int i = 0; i < WORDS_A; i++) begin
            logic [7:0] v;
            v = 8'((EXP_INIT + i * EXP_STEP) % 256);
            if ($urandom_range(15) == 0) v = v ^ 8'($urandom_range(1, 255));
            fifoQ.push_back(v);
        end
        emptyPct = 30;
        startRun();
        runUntilDone("rand", 3000);
        emptyPct = 0;
        checkStatus("rand", 0);

        // Reset pulse mid-run, then a fresh clean run
        loadRamp(WORDS_A);
        startRun();
        runUntilCount("t5", 40, 200);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkStatus("t5_rst", 0);
        checkOutput("t5_rst_words", 32'(wordCount[0]), 32'd0);
        loadRamp(WORDS_A);
        startRun();
        applyStimulus();
        checkOutput("t5_word0", 32'(wordCount[0]), 32'd1);
        checkOutput("t5_word0_ok", 32'(errFlag[0]), 32'd0);
        runUntilDone("t5", 400);
        checkStatus("t5", 0);

        // 200-word run with GAP=3: ramp wraps at word 128
        activeSel = 1;
        modelReset();
        loadRamp(WORDS_B);
        popCycles.delete();
        startRun();
        runUntilDone("t6", 1200);
        checkStatus("t6", 1);
        checkOutput("t6_words", 32'(wordCount[1]), 32'd200);
        checkOutput("t6_errs", 32'(errCount[1]), 32'd0);
        checkOutput("t6_pops", 32'(popCycles.size()), 32'd200);
        badGaps = 0;
        for (int i = 1; i < popCycles.size(); i++) begin
            if (popCycles[i] - popCycles[i-1] != 4) badGaps++;
        end
        checkOutput("t4_spacing", 32'(badGaps), 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus();
        checkStatus("t6_hold", 1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
